// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the bit-serial add/subtract controller.
//   state_t   : controller FSM encoding (IDLE, RUN, DONE)
//   cnt_width : bit-counter width for a given operand width

package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter has to hold values 0..width-1, and it always needs at least one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell
// Combinational 1-bit full adder. It is the only adder in the serial datapath.
//   a, b, cin : operand bits and carry-in
//   sum, cout : sum bit and carry-out

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial add/subtract controller. It processes one operand bit per clock,
// LSB first, through a single fa_cell.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready is high only in IDLE)
//   a, b, cin, sub        : operands, carry/borrow-in, 0=add 1=subtract
//   out_valid / out_ready : result handshake (out_valid is high only in DONE)
//   sum, cout, ovf        : registered result, carry (no-borrow when subtracting),
//                           signed overflow
//   busy                  : high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | shifting one bit per clock through the adder cell
// DONE  | result held until the consumer accepts it

module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(WIDTH - 2);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] res_sh;     // sum bits collected so far; the MSB side holds the newest bit
    logic             carry;
    logic             cmsb;       // carry into the MSB, used for signed overflow
    logic [CNT_W-1:0] cnt;

    logic             s_bit;
    logic             c_bit;
    logic [WIDTH-1:0] res_next;

    fa_cell u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (s_bit),
        .cout (c_bit)
    );

    // On the last RUN edge this is already the complete result.
    assign res_next = {s_bit, res_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res_sh    <= '0;
            carry     <= 1'b0;
            cmsb      <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1; a borrow-in takes away the +1.
                        op_a     <= a;
                        op_b     <= sub ? ~b : b;
                        carry    <= cin ^ sub;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    res_sh <= res_next[WIDTH-1:1];
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= c_bit;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_PEN) begin
                        cmsb <= c_bit;
                    end
                    if (cnt == CNT_LAST) begin
                        sum       <= res_next;
                        cout      <= c_bit;
                        ovf       <= c_bit ^ cmsb;
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        exp_t         e;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[7];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference arithmetic on plain integers: a +/- b +/- cin.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input logic is);
        exp_t e;
        int ua, ub, uc, sa, sb, r, sr;
        ua = int'(ia);
        ub = int'(ib);
        uc = int'(ic);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        if (!is) begin
            r    = ua + ub + uc;
            sr   = sa + sb + uc;
            e.co = (r > 15);
        end else begin
            r    = ua - ub - uc;
            sr   = sa - sb - uc;
            e.co = (ua >= ub + uc);
        end
        e.s  = r[W-1:0];
        e.ov = (sr > 7) || (sr < -8);
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) fail_now("wait_in_ready");
    endtask

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ic, input logic is, input exp_t e);
        wait_ready();
        a = ia; b = ib; cin = ic; sub = is;
        in_valid = 1'b1;
        @(posedge clk);
        sbq.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) fail_now("wait_out_valid");
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            fail_now({tag, "_scoreboard_empty"});
        end else begin
            e = sbq.pop_front();
            check({tag, "_sum"}, sum, e.s);
            check({tag, "_cout"}, cout, e.co);
            check({tag, "_ovf"}, ovf, e.ov);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   last_acc;
        int   bad;
        exp_t e;

        vecs[0] = '{a: 4'd3,  b: 4'd5, cin: 1'b0, sub: 1'b0, e: '{s: 4'd8,  co: 1'b0, ov: 1'b1}};
        vecs[1] = '{a: 4'd15, b: 4'd1, cin: 1'b0, sub: 1'b0, e: '{s: 4'd0,  co: 1'b1, ov: 1'b0}};
        vecs[2] = '{a: 4'd0,  b: 4'd0, cin: 1'b1, sub: 1'b0, e: '{s: 4'd1,  co: 1'b0, ov: 1'b0}};
        vecs[3] = '{a: 4'd2,  b: 4'd5, cin: 1'b0, sub: 1'b1, e: '{s: 4'd13, co: 1'b0, ov: 1'b0}};
        vecs[4] = '{a: 4'd8,  b: 4'd1, cin: 1'b0, sub: 1'b1, e: '{s: 4'd7,  co: 1'b1, ov: 1'b1}};
        vecs[5] = '{a: 4'd5,  b: 4'd2, cin: 1'b1, sub: 1'b1, e: '{s: 4'd2,  co: 1'b1, ov: 1'b0}};
        vecs[6] = '{a: 4'd7,  b: 4'd7, cin: 1'b0, sub: 1'b0, e: '{s: 4'd14, co: 1'b0, ov: 1'b1}};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, each one a complete accept/compute/handshake cycle
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].e);
            check("run_busy", busy, 1);
            wait_valid(lat);
            check("latency", lat, W);
            if (out_valid) check_out($sformatf("vec%0d", i));
            @(posedge clk); #1;
            check("post_hs_out_valid", out_valid, 0);
            check("post_hs_in_ready", in_ready, 1);
        end

        // Backpressure, with a competing request while DONE
        out_ready = 1'b0;
        start_op(4'd6, 4'd6, 1'b0, 1'b0, model(4'd6, 4'd6, 1'b0, 1'b0));
        wait_valid(lat);
        in_valid = 1'b1; a = 4'd9; b = 4'd0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("bp_sum", sum, 12);
            check("bp_cout", cout, 0);
            check("bp_ovf", ovf, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        check_out("bp");
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_hold_sum", sum, 12);

        // Reset asserted during the second RUN cycle
        start_op(4'd1, 4'd2, 1'b0, 1'b0, model(4'd1, 4'd2, 1'b0, 1'b0));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        check("midrst_ovf", ovf, 0);
        sbq.delete();
        @(posedge clk); #2;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("midrst_no_out_valid", bad, 0);
        start_op(vecs[6].a, vecs[6].b, vecs[6].cin, vecs[6].sub, vecs[6].e);
        wait_valid(lat);
        if (out_valid) check_out("after_rst");
        @(posedge clk); #1;

        // Back-to-back random operations, in_valid and out_ready held high
        wait_ready();
        out_ready = 1'b1;
        in_valid = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 20; i++) begin
            a   = W'($urandom_range(0, 15));
            b   = W'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            e   = model(a, b, cin, sub);
            check("b2b_ready", in_ready, 1);
            @(posedge clk);
            sbq.push_back(e);
            #1;
            if (i > 0) check("b2b_spacing", cyc - last_acc, W + 2);
            last_acc = cyc;
            wait_valid(lat);
            check("b2b_latency", lat, W);
            if (out_valid) check_out($sformatf("b2b%0d", i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
